// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared FSM encodings and default geometry for the cache controller
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } lookup_state_t;

  localparam int DEF_TAG_W = 8;
  localparam int DEF_WAYS  = 4;

endpackage

// File: rtl/bitwise_comparator.sv
// rtl/bitwise_comparator.sv - equality comparator built from a bitwise XOR reduction
module bitwise_comparator #(
  parameter int w = 8
) (
  input  logic [w-1:0] in_0,
  input  logic [w-1:0] in_1,
  output logic         eq
);

  assign eq = ~|(in_0 ^ in_1);

endmodule

// File: rtl/tag_lookup_sequencer.sv
// rtl/tag_lookup_sequencer.sv - walks the ways of one set through a single shared tag comparator
module tag_lookup_sequencer
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int WAYS  = DEF_WAYS,
  parameter int WAY_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             tag_rd_en,
  output logic [WAY_W-1:0] tag_rd_way,
  input  logic [TAG_W-1:0] tag_rd_data,
  input  logic             tag_rd_vld,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  input  logic             resp_ready
);

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  lookup_state_t    state;
  logic [TAG_W-1:0] tag_q;
  logic [WAY_W-1:0] way_q;
  logic             tag_eq;
  logic             way_hit;

  bitwise_comparator #(.w(TAG_W)) u_cmp (
    .in_0 (tag_q),
    .in_1 (tag_rd_data),
    .eq   (tag_eq)
  );

  // A matching tag only counts when the stored entry is valid
  assign way_hit = tag_eq & tag_rd_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tag_q    <= '0;
      way_q    <= '0;
      resp_hit <= 1'b0;
      resp_way <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tag_q <= req_tag;
            way_q <= '0;
            state <= ST_READ;
          end
        end
        ST_READ: state <= ST_CMP;
        ST_CMP: begin
          if (way_hit) begin
            resp_hit <= 1'b1;
            resp_way <= way_q;
            state    <= ST_RESP;
          end else if (way_q == LAST_WAY) begin
            resp_hit <= 1'b0;
            resp_way <= '0;
            state    <= ST_RESP;
          end else begin
            way_q <= way_q + WAY_W'(1);
            state <= ST_READ;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Remaining outputs are pure decodes of registered state
  assign req_ready  = (state == ST_IDLE);
  assign tag_rd_en  = (state == ST_READ);
  assign tag_rd_way = way_q;
  assign resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_tag_lookup_sequencer.sv
// tb/tb_tag_lookup_sequencer.sv - scoreboard bench for tag_lookup_sequencer
module tb_tag_lookup_sequencer;

  localparam int TAG_W = 8;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic             tag_rd_en;
  logic [WAY_W-1:0] tag_rd_way;
  logic [TAG_W-1:0] tag_rd_data;
  logic             tag_rd_vld;
  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic             resp_ready;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
    int         lat;
    int         nreads;
  } exp_t;

  logic [TAG_W-1:0] mem_tag [WAYS];
  logic             mem_vld [WAYS];
  exp_t             sb [$];
  int               read_log [$];
  int               cyc = 0;
  int               acc_cyc = 0;
  logic             prev_rv = 1'b0;
  int               checks = 0;
  int               failures = 0;

  tag_lookup_sequencer #(.TAG_W(TAG_W), .WAYS(WAYS), .WAY_W(WAY_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .tag_rd_en   (tag_rd_en),
    .tag_rd_way  (tag_rd_way),
    .tag_rd_data (tag_rd_data),
    .tag_rd_vld  (tag_rd_vld),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .resp_ready  (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Tag array model with one-cycle read latency
  always @(posedge clk) begin
    cyc++;
    if (tag_rd_en) begin
      tag_rd_data <= mem_tag[tag_rd_way];
      tag_rd_vld  <= mem_vld[tag_rd_way];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        read_log.delete();
      end
      if (tag_rd_en) read_log.push_back(int'(tag_rd_way));
      if (resp_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("resp_hit", resp_hit, e.hit);
          check("resp_way", resp_way, e.way);
          check("latency", cyc - acc_cyc, e.lat);
          check("read_count", read_log.size(), e.nreads);
          for (int i = 0; i < read_log.size(); i++) check("read_order", read_log[i], i);
        end
      end
      prev_rv = resp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic hit, input logic [1:0] way, input int lat, input int nreads);
    exp_t e;
    e.hit = hit; e.way = way; e.lat = lat; e.nreads = nreads;
    sb.push_back(e);
  endtask

  task automatic set_mem(input logic [31:0] tags, input logic [3:0] vlds);
    for (int i = 0; i < WAYS; i++) begin
      mem_tag[i] = tags[8*i +: 8];
      mem_vld[i] = vlds[i];
    end
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!resp_valid) check("resp_timeout", 0, 1);
  endtask

  task automatic wait_resp;
    wait_valid();
    tick();
  endtask

  initial begin
    logic seen_rv;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_tag    = '0;
    resp_ready = 1'b1;
    set_mem(32'h0, 4'h0);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rd_en", tag_rd_en, 0);
    check("rst_rd_way", tag_rd_way, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", req_ready, 1);

    // Hit in way 0
    set_mem(32'h0000_00A5, 4'b0001);
    push(1'b1, 2'd0, 2, 1);
    issue(8'hA5);
    wait_resp();

    // Hit in way 2; duplicate in way 3 must not be read
    set_mem(32'hA5A5_2211, 4'b1111);
    push(1'b1, 2'd2, 6, 3);
    issue(8'hA5);
    wait_resp();

    // Asynchronous reset during CMP of way 1 discards the lookup
    set_mem(32'h0000_0000, 4'b1111);
    push(1'b0, 2'd0, 8, 4);
    issue(8'h77);
    tick(); tick(); tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", tag_rd_en, 0);
    check("midrst_rd_way", tag_rd_way, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_hit", resp_hit, 0);
    check("midrst_resp_way", resp_way, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", req_ready, 1);
    seen_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_rv |= resp_valid;
      tick();
    end
    check("midrst_no_resp", seen_rv, 0);

    // Matching tag with valid=0 is a miss
    set_mem(32'h3020_3C10, 4'b1101);
    push(1'b0, 2'd0, 8, 4);
    issue(8'h3C);
    wait_resp();

    // Response backpressure
    set_mem(32'h0000_5AA5, 4'b0011);
    resp_ready = 1'b0;
    push(1'b1, 2'd0, 2, 1);
    issue(8'hA5);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_hit", resp_hit, 1);
      check("bp_way", resp_way, 0);
      check("bp_ready", req_ready, 0);
      req_valid = i[0];
      req_tag   = 8'h3C;
      tick();
    end
    push(1'b1, 2'd1, 4, 2);
    req_valid  = 1'b1;
    req_tag    = 8'h5A;
    resp_ready = 1'b1;
    tick();
    check("bp_release_valid", resp_valid, 0);
    check("bp_release_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("bp_next_accepted", req_ready, 0);
    wait_resp();

    // req_tag changes after acceptance must be ignored
    set_mem(32'hA502_0100, 4'b1111);
    push(1'b1, 2'd3, 8, 4);
    issue(8'hA5);
    req_tag = 8'h00;
    wait_resp();

    tick();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_lookup_sequencer.md
# tag_lookup_sequencer

Sequences a set-associative tag lookup over a single shared tag comparator, one way at a time. It accepts a lookup request carrying a tag and reads each way's tag/valid pair from the tag array, which has 1-cycle read latency. It compares each pair and returns hit/miss plus the hit way. It sits between the cache controller's request front-end and the tag array.

## Interface
Parameters:
- TAG_W, 8, tag width in bits; also the width of the comparator.
- WAYS, 4, associativity; must be ≥2.
- WAY_W, 2, width of a way index; must equal clog2(WAYS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  lookup request valid.
- req_tag  in  TAG_W  tag to look up.
- req_ready  out  1  high only in IDLE.
- tag_rd_en  out  1  tag array read strobe.
- tag_rd_way  out  WAY_W  way being read.
- tag_rd_data  in  TAG_W  stored tag; valid 1 cycle after tag_rd_en.
- tag_rd_vld  in  1  stored valid bit; same timing as tag_rd_data.
- resp_valid  out  1  response valid.
- resp_hit  out  1  1 = hit.
- resp_way  out  WAY_W  hit way; 0 on miss.
- resp_ready  in  1  consumer accepts response.

## Operation
- State machine with four states.
  - IDLE: req_ready=1. On req_valid: latch req_tag into tag_q, clear way_q to 0, go to READ.
  - READ: tag_rd_en=1 and tag_rd_way=way_q. Always go to CMP.
  - CMP: compare tag_q against tag_rd_data through the comparator; hit = eq & tag_rd_vld.
    - Hit: resp_hit←1, resp_way←way_q, go to RESP.
    - Miss with way_q==WAYS-1: resp_hit←0, resp_way←0, go to RESP.
    - Otherwise: way_q←way_q+1, go to READ.
- RESP: resp_valid=1, with resp_hit and resp_way held stable. On resp_ready, go to IDLE.
- Search order is way 0 upward. The first hit terminates the search, so a duplicate tag in a higher way is never reported.
- Outside READ, tag_rd_en=0 and tag_rd_way=way_q.
- req_tag is sampled only on the accepting edge. Later changes have no effect on the lookup in flight.
- Moore outputs only; there is no combinational path from any input to any output.

## Timing
- Reset (asynchronous, immediate) puts every output in a defined state:
  - State = IDLE.
  - tag_q=0 and way_q=0.
  - resp_valid=0, resp_hit=0, resp_way=0.
  - tag_rd_en=0 and tag_rd_way=0.
  - req_ready=1 once reset deasserts.
- Reset mid-lookup or mid-response discards the transaction; no response is issued.
- Request accepted at edge E:
  - READ of way k occurs in the cycle after edge E+2k.
  - Hit on way k: resp_valid is first high after edge E+2k+2.
  - Full miss: resp_valid is first high after edge E+2·WAYS.
- resp_valid is held for as long as resp_ready stays low. Leaving RESP on the resp_ready edge returns the block to IDLE.
- A request arriving in the cycle resp_valid drops is accepted one cycle later, since req_ready only rises in IDLE. Back-to-back throughput is therefore at least 1 idle cycle per lookup.
- Valid bit = 0 with a matching tag is a miss for that way.

## Structure
- Shared package cache_ctrl_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_READ=2'd1, ST_CMP=2'd2, ST_RESP=2'd3;
  - default TAG_W/WAYS constants.
- Sub-module: one bitwise_comparator instance, with w=TAG_W, in_0=tag_q, in_1=tag_rd_data. Its eq output is ANDed with tag_rd_vld locally.
- The way counter and the state register live in this module; no further sub-modules.

## Test plan
Configuration for all scenarios: TAG_W=8, WAYS=4.
- Reset: assert rst_n=0 mid-CMP → outputs go to their reset values immediately, with no clock edge; req_ready=1 after release.
- Hit in way 0: tag array way0={0xA5,vld=1}, request 0xA5 → one READ of way 0; resp_valid after edge E+2 with hit=1, way=0.
- Hit in way 2: ways 0–3 hold {0x11,0x22,0xA5,0xA5}, all valid → reads of ways 0,1,2 only; resp after edge E+6 with hit=1, way=2. Way 3 is never read.
- Invalid match: way1={0x3C,vld=0}, others ≠0x3C → reads of all 4 ways; miss after edge E+8 with hit=0, way=0.
- Response backpressure: hit on way 0, hold resp_ready=0 for 5 cycles → resp_valid/hit/way stable throughout. req_ready=0 and req_valid pulses are ignored until resp_ready=1; the next request is accepted the following cycle.
- Tag sampling: change req_tag from 0xA5 to 0x00 the cycle after acceptance, with way3=0xA5 → hit way 3 after edge E+8.
